// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, complex sample type and index bit-reversal
// for the FFT output path; imported by the serializer, its bank and bus.
package fft_pkg;

  localparam int FFT_N     = 8;
  localparam int FFT_LOG2N = $clog2(FFT_N);
  localparam int FFT_CW    = 25;
  localparam int FFT_DW    = 2 * FFT_CW;

  typedef struct packed {
    logic signed [FFT_CW-1:0] re;
    logic signed [FFT_CW-1:0] im;
  } cplx_t;

  // Reverses the low w bits of idx.
  function automatic int unsigned bitrev(
    input int unsigned idx,
    input int unsigned w = FFT_LOG2N
  );
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < w; b++) begin
      r = r | (((idx >> b) & 32'd1) << (w - 1 - b));
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_serializer_if.sv
// fft_frame_serializer_if: parallel frame in, natural-order sample stream out.
// master drives frames / sample ready; slave (serializer) drives the rest.
interface fft_frame_serializer_if #(
  parameter int N  = fft_pkg::FFT_N,
  parameter int CW = fft_pkg::FFT_CW
);
  localparam int LOG2N = $clog2(N);
  localparam int DW    = 2 * CW;

  logic [DW-1:0]    frame_i [N];
  logic             frame_valid_i;
  logic             frame_ready_o;
  logic [DW-1:0]    sample_o;
  logic [LOG2N-1:0] sample_idx_o;
  logic             sample_valid_o;
  logic             sample_last_o;
  logic             sample_ready_i;

  modport master (
    output frame_i,
    output frame_valid_i,
    input  frame_ready_o,
    input  sample_o,
    input  sample_idx_o,
    input  sample_valid_o,
    input  sample_last_o,
    output sample_ready_i
  );

  modport slave (
    input  frame_i,
    input  frame_valid_i,
    output frame_ready_o,
    output sample_o,
    output sample_idx_o,
    output sample_valid_o,
    output sample_last_o,
    input  sample_ready_i
  );

endinterface

// File: rtl/fft_bank_pingpong.sv
// fft_bank_pingpong: two frame banks with full flags and write pointer.
// Ports: clk_i/rst_ni, i_frame/i_wr_en write, i_rd_ptr/i_rd_addr/i_rd_clr read,
// o_full, o_wr_ptr, o_rd_data.
module fft_bank_pingpong
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int DW = FFT_DW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DW-1:0]        i_frame [N],
  input  logic                 i_wr_en,
  input  logic                 i_rd_ptr,
  input  logic [$clog2(N)-1:0] i_rd_addr,
  input  logic                 i_rd_clr,
  output logic [1:0]           o_full,
  output logic                 o_wr_ptr,
  output logic [DW-1:0]        o_rd_data
);

  logic [DW-1:0] r_bank [2][N];
  logic [1:0]    r_full;
  logic          r_wr_ptr;

  always_ff @(posedge clk_i) begin
    if (i_wr_en) begin
      for (int j = 0; j < N; j++) begin
        r_bank[r_wr_ptr][j] <= i_frame[j];
      end
    end
  end

  // Write and clear never hit the same bank: a write needs the bank
  // empty, a clear needs it full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full   <= '0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_full[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (i_rd_clr) begin
        r_full[i_rd_ptr] <= 1'b0;
      end
    end
  end

  assign o_full    = r_full;
  assign o_wr_ptr  = r_wr_ptr;
  assign o_rd_data = r_bank[i_rd_ptr][i_rd_addr];

endmodule

// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer: bit-reversed parallel frame -> natural-order stream.
// Ports: clk_i, rst_ni, bus (slave). Option: FFT_SERIALIZER_OUT_SCALE_EN.
module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int CW = FFT_CW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fft_frame_serializer_if.slave bus
);

  localparam int LOG2N = $clog2(N);
  localparam int DW    = 2 * CW;

  localparam logic [0:0] RD_IDLE   = 1'b0;
  localparam logic [0:0] RD_STREAM = 1'b1;

  logic [1:0]       w_full;
  logic             w_wr_ptr;
  logic             w_frame_ready;
  logic             w_wr_en;
  logic [0:0]       w_rd_state;
  logic             w_valid;
  logic             w_last;
  logic             w_fire;
  logic             w_rd_clr;
  logic [LOG2N-1:0] w_rd_addr;
  logic [DW-1:0]    w_rd_data;
  logic [DW-1:0]    w_out;

  logic             r_rd_ptr;
  logic [LOG2N-1:0] r_rd_idx;

  assign w_frame_ready = !w_full[w_wr_ptr];
  assign w_wr_en       = bus.frame_valid_i && w_frame_ready;

  // The read bank's full flag is the read state.
  assign w_rd_state = w_full[r_rd_ptr];
  assign w_valid    = (w_rd_state == RD_STREAM);
  assign w_last     = w_valid && (r_rd_idx == LOG2N'(N - 1));
  assign w_fire     = w_valid && bus.sample_ready_i;
  assign w_rd_clr   = w_fire && w_last;
  assign w_rd_addr  = LOG2N'(bitrev(32'(r_rd_idx), LOG2N));

  fft_bank_pingpong #(
    .N  (N),
    .DW (DW)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_frame   (bus.frame_i),
    .i_wr_en   (w_wr_en),
    .i_rd_ptr  (r_rd_ptr),
    .i_rd_addr (w_rd_addr),
    .i_rd_clr  (w_rd_clr),
    .o_full    (w_full),
    .o_wr_ptr  (w_wr_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= 1'b0;
      r_rd_idx <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_rd_idx <= '0;
        r_rd_ptr <= ~r_rd_ptr;
      end else begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end
    end
  end

`ifdef FFT_SERIALIZER_OUT_SCALE_EN
  // Divide by N, round half up; one guard bit keeps the add exact.
  function automatic logic [CW-1:0] scale(
    input logic [CW-1:0] x
  );
    logic signed [CW:0] s;
    s = $signed({x[CW-1], x}) + $signed((CW+1)'(N / 2));
    return CW'(s >>> LOG2N);
  endfunction

  assign w_out = {scale(w_rd_data[DW-1:CW]),
                  scale(w_rd_data[CW-1:0])};
`else
  assign w_out = w_rd_data;
`endif

  assign bus.frame_ready_o  = w_frame_ready;
  assign bus.sample_valid_o = w_valid;
  assign bus.sample_last_o  = w_last;
  assign bus.sample_o       = w_valid ? w_out : '0;
  assign bus.sample_idx_o   = w_valid ? r_rd_idx : '0;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// tb_fft_frame_serializer: random and directed frames against a queue model
// of natural-order output; checks data, index, last, valid and frame_ready.
module tb_fft_frame_serializer;
  import fft_pkg::*;

  localparam int N     = FFT_N;
  localparam int LOG2N = FFT_LOG2N;
  localparam int CW    = FFT_CW;
  localparam int DW    = FFT_DW;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  fft_frame_serializer_if #(.N(N), .CW(CW)) bus();

  fft_frame_serializer #(.N(N), .CW(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int rdy_pct = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } exp_t;

  exp_t exp_q[$];
  logic [DW-1:0] frm [N];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Natural bin held by bit-reversed slot j.
  function automatic int rev(int j);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      if (((j >> b) % 2) == 1) r += 2 ** (LOG2N - 1 - b);
    end
    return r;
  endfunction

  function automatic longint sx(logic [CW-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic logic [DW-1:0] model_out(longint re, longint im);
    longint r;
    longint i;
    logic [63:0] rv;
    logic [63:0] iv;
    r = re;
    i = im;
`ifdef FFT_SERIALIZER_OUT_SCALE_EN
    r = (re + N / 2) >>> LOG2N;
    i = (im + N / 2) >>> LOG2N;
`endif
    rv = r;
    iv = i;
    return {rv[CW-1:0], iv[CW-1:0]};
  endfunction

  // Driven after each rising edge; rdy_pct selects stall pattern.
  always @(posedge clk) begin
    #1;
    bus.sample_ready_i = ($urandom_range(99) < rdy_pct);
  end

  // Monitor: compare the stream against the model on every falling edge.
  logic [DW-1:0] nat [N];
  always @(negedge clk) begin
    if (rst_ni) begin
      chk("valid", bus.sample_valid_o, exp_q.size() != 0);
      if (bus.sample_valid_o && exp_q.size() != 0) begin
        chk("data", bus.sample_o, exp_q[0].data);
        chk("idx", bus.sample_idx_o, exp_q[0].idx);
        chk("last", bus.sample_last_o, exp_q[0].idx == N - 1);
        if (bus.sample_ready_i) void'(exp_q.pop_front());
      end else if (!bus.sample_valid_o) begin
        chk("idle_out", {bus.sample_last_o, bus.sample_idx_o,
                         bus.sample_o}, 0);
      end
      if (bus.frame_valid_i && bus.frame_ready_o) begin
        for (int j = 0; j < N; j++) nat[rev(j)] = bus.frame_i[j];
        for (int k = 0; k < N; k++) begin
          exp_q.push_back('{data: model_out(sx(nat[k][DW-1:CW]),
                                            sx(nat[k][CW-1:0])),
                            idx: k});
        end
      end
    end
  end

  task automatic load();
    for (int j = 0; j < N; j++) bus.frame_i[j] = frm[j];
  endtask

  task automatic send();
    logic acc = 1'b0;
    load();
    bus.frame_valid_i = 1'b1;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      if (bus.frame_ready_o) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.frame_valid_i = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic set_frame(logic [CW-1:0] re, logic [CW-1:0] im);
    for (int j = 0; j < N; j++) frm[j] = {re, im};
  endtask

  initial begin : main
    int tab [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [63:0] t;
    logic [DW-1:0] want;
    logic found;

    bus.frame_valid_i = 1'b0;
    bus.sample_ready_i = 1'b0;
    for (int j = 0; j < N; j++) bus.frame_i[j] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.frame_ready_o, 1);
    chk("rst_valid", bus.sample_valid_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.frame_ready_o, 1);
    chk("post_rst_out", {bus.sample_valid_o, bus.sample_last_o,
                         bus.sample_idx_o, bus.sample_o}, 0);

    // Frame j = {j, -j}: natural order 0,4,2,6,1,5,3,7.
    rdy_pct = 100;
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) frm[j] = {CW'(j), CW'(-j)};
    send();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      want = model_out(tab[k], -tab[k]);
      chk("t1_valid", bus.sample_valid_o, 1);
      chk("t1_idx", bus.sample_idx_o, k);
      chk("t1_data", bus.sample_o, want);
      chk("t1_last", bus.sample_last_o, k == N - 1);
    end
    drain();

    // Both banks filled while stalled; third frame must wait.
    rdy_pct = 0;
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) frm[j] = {CW'(10 + j), CW'(20 + j)};
    send();
    for (int j = 0; j < N; j++) frm[j] = {CW'(30 + j), CW'(40 + j)};
    send();
    for (int j = 0; j < N; j++) frm[j] = {CW'(50 + j), CW'(60 + j)};
    load();
    bus.frame_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("b2b_full_ready", bus.frame_ready_o, 0);
    end
    rdy_pct = 100;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (bus.sample_valid_o && bus.sample_ready_i && bus.sample_last_o) begin
        chk("b2b_ready_at_last", bus.frame_ready_o, 0);
        @(negedge clk);
        chk("b2b_ready_after", bus.frame_ready_o, 1);
        found = 1'b1;
      end
    end
    chk("b2b_last_seen", found, 1);
    @(posedge clk);
    #1;
    bus.frame_valid_i = 1'b0;
    drain();

    // Extremes in every slot.
    set_frame(CW'(-(2 ** 24)), CW'(2 ** 24 - 1));
    send();
    @(negedge clk);
`ifdef FFT_SERIALIZER_OUT_SCALE_EN
    t = 64'(-2097152);
    chk("ext_re_scaled", bus.sample_o[DW-1:CW], t[CW-1:0]);
`else
    want = {CW'(-(2 ** 24)), CW'(2 ** 24 - 1)};
    chk("ext_exact", bus.sample_o, want);
`endif
    drain();

`ifdef FFT_SERIALIZER_OUT_SCALE_EN
    set_frame(CW'(12), CW'(-12));
    send();
    @(negedge clk);
    want = {CW'(2), CW'(-1)};
    chk("scale_12", bus.sample_o, want);
    drain();
`endif

    // Random data, random stalls.
    rdy_pct = 50;
    for (int f = 0; f < 100; f++) begin
      for (int j = 0; j < N; j++) begin
        t = {$urandom, $urandom};
        frm[j] = t[DW-1:0];
      end
      send();
    end
    rdy_pct = 100;
    drain();

    // Reset in the middle of a frame.
    for (int j = 0; j < N; j++) frm[j] = {CW'(100 + j), CW'(200 + j)};
    send();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.sample_valid_o && bus.sample_idx_o == LOG2N'(3)) found = 1'b1;
    end
    chk("mid_idx3_seen", found, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ready", bus.frame_ready_o, 1);
    chk("mid_rst_out", {bus.sample_valid_o, bus.sample_last_o,
                        bus.sample_idx_o, bus.sample_o}, 0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) frm[j] = {CW'(300 + j), CW'(400 + j)};
    send();
    @(negedge clk);
    chk("mid_restart_idx", bus.sample_idx_o, 0);
    chk("mid_restart_valid", bus.sample_valid_o, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_serializer.md
Name: fft_frame_serializer

Overview:
- Output-side reader for the 8-point DIF butterfly pipeline.
- Accepts one complete parallel frame of 8 complex samples per handshake; the frame arrives in bit-reversed bin order.
- Streams the samples out one per cycle in natural bin order, with valid/ready and last.
- Two-bank ping-pong storage, so the next frame is accepted while the current one drains.

Parameters:
- N, 8: points per frame; power of two, at least 2.
- LOG2N, $clog2(N): index width.
- CW, 25: width of each real/imaginary component (two's complement).
- DW, 2*CW: packed complex width; real part in [DW-1:CW], imaginary part in [CW-1:0].

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: asynchronous active-low reset.
- frame_i, input, N x DW: unpacked array; element j is the butterfly output in bit-reversed position j.
- frame_valid_i, input, 1: frame_i holds a complete frame.
- frame_ready_o, output, 1: a bank is free to accept a frame.
- sample_o, output, DW: current natural-order sample.
- sample_idx_o, output, LOG2N: natural bin index of sample_o.
- sample_valid_o, output, 1: sample_o is valid.
- sample_last_o, output, 1: sample_o is bin N-1 of its frame.
- sample_ready_i, input, 1: consumer accepts sample_o.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - Reset values: both banks empty; wr_ptr=0, rd_ptr=0, rd_idx=0.
  - Outputs at reset: frame_ready_o=1, sample_valid_o=0, sample_last_o=0, sample_o=0, sample_idx_o=0.
  - Bank data registers are not reset.
- Per-bank state: full[1:0] flags.
  - frame_ready_o = !full[wr_ptr].
  - frame_ready_o is registered-state only, with no combinational path from sample_ready_i.
- Write: when frame_valid_i && frame_ready_o, capture all N elements into bank[wr_ptr], set full[wr_ptr], toggle wr_ptr.
- Read state machine per rd_ptr bank: IDLE (bank empty) -> STREAM (bank full) -> IDLE on the last handshake.
  - sample_valid_o = full[rd_ptr].
  - sample_o = bank[rd_ptr][bitrev(rd_idx)], where bitrev reverses all LOG2N bits. For N=8: 0,4,2,6,1,5,3,7.
  - sample_idx_o = rd_idx.
  - sample_last_o = sample_valid_o && rd_idx==N-1.
  - sample_o and sample_idx_o are forced to 0 while sample_valid_o=0.
  - On sample_valid_o && sample_ready_i: rd_idx++. If last: rd_idx wraps to 0, clear full[rd_ptr], toggle rd_ptr.
- Latency: a frame accepted on edge T presents bin 0 on the cycle after T, provided the read bank was idle. Sustained throughput is one frame per N cycles.
- Backpressure: while sample_ready_i=0, sample_o, sample_idx_o and sample_last_o hold stable; rd_idx does not advance.
- Both banks full: frame_ready_o=0. Frame inputs are ignored even if frame_valid_i=1.
- Simultaneous write and last-read on different banks: both take effect.
  - A bank freed by the last handshake becomes writable on the following cycle, not the same cycle.
- Reset asserted mid-stream: the in-flight frame is discarded and all state returns immediately to reset values.
- Data passes bit-exact unless OUT_SCALE_EN is defined.

Optional Feature:
- Macro: FFT_SERIALIZER_OUT_SCALE_EN.
- Defined: each component of sample_o is divided by N with round-half-up, i.e. (x + 2^(LOG2N-1)) >>> LOG2N, arithmetically.
  - The result is sign-extended back to CW bits.
  - The addition is performed in CW+1 bits, so there is no overflow.
- Undefined: sample_o equals the stored value bit-exact.
- The feature adds no latency in either configuration.

Decomposition:
- Shared package fft_pkg holds:
  - constants FFT_N, FFT_LOG2N, FFT_CW, FFT_DW;
  - typedef cplx_t, a packed struct {logic signed [CW-1:0] re, im};
  - function bitrev(idx).
- One sub-module, fft_bank_pingpong: the two bank arrays, full flags and wr_ptr.
- The read counter, output mux and scaling stay in the top module.

Test Plan:
- Reset check: after reset, frame_ready_o=1 and sample_valid_o=0. Drive frame j = {re=j, im=-j} for j=0..7 with sample_ready_i=1 -> 8 consecutive samples in this order: idx0 {0,0}, idx1 {4,-4}, idx2 {2,-2}, idx3 {6,-6}, idx4 {1,-1}, idx5 {5,-5}, idx6 {3,-3}, idx7 {7,-7}. sample_last_o=1 on idx7 only.
- Back-to-back: three frames offered with frame_valid_i held and sample_ready_i=0 -> frames 1 and 2 are accepted, frame_ready_o=0 on the third. Release sample_ready_i -> frame_ready_o rises on the cycle after frame 1's idx7 handshake.
- Random sample_ready_i (50%) over 100 frames -> scoreboard matches natural order. Outputs stay stable while stalled; there are no drops or duplicates.
- Extremes: re=-2^24, im=2^24-1 in every slot -> passed bit-exact with no sign corruption.
- Reset mid-stream: assert rst_ni at idx3 -> outputs are 0 and frame_ready_o=1 immediately. The next frame starts at idx0.
- FFT_SERIALIZER_OUT_SCALE_EN defined: input re=12, im=-12 -> re=2, im=-1. Input re=-16777216 -> -2097152.
